// File: rtl/uart_stream_pkg.sv
// uart_stream_pkg
//   Definitions shared by the UART count streamer family:
//   - stream_state_e    : frame sequencer states (IDLE, ISSUE, WAIT, ADVANCE)
//   - DEFAULT_SYNC_BYTE : header byte placed in front of each frame
//   - bytes_per_word()  : number of payload bytes in a WIDTH-bit word
package uart_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_ADVANCE = 2'd3
  } stream_state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/count_step_unit.sv
// count_step_unit
//   Next-count logic for a wrapping up/down counter with a programmable
//   step and inclusive upper limit, plus clamping of load values.
//   Purely combinational so several channels can share the same shape.
// Ports:
//   i_Count         current counter value
//   i_Dir           0 = count up, 1 = count down
//   i_Load_Pending  1 = a deferred load takes priority over stepping
//   i_Pending_Val   deferred load value (already clamped)
//   i_Load_Val      raw load value to clamp
//   o_Next_Count    value the counter takes when it advances
//   o_Load_Clamped  min(i_Load_Val, MAX_COUNT)
module count_step_unit #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] STEP      = WIDTH'(1)
) (
  input  logic [WIDTH-1:0] i_Count,
  input  logic             i_Dir,
  input  logic             i_Load_Pending,
  input  logic [WIDTH-1:0] i_Pending_Val,
  input  logic [WIDTH-1:0] i_Load_Val,
  output logic [WIDTH-1:0] o_Next_Count,
  output logic [WIDTH-1:0] o_Load_Clamped
);

  // One extra bit keeps MAX_COUNT-STEP and the compares free of overflow.
  logic [WIDTH:0] count_ext_s;
  logic [WIDTH:0] step_ext_s;
  logic [WIDTH:0] up_limit_s;

  assign count_ext_s = {1'b0, i_Count};
  assign step_ext_s  = {1'b0, STEP};
  assign up_limit_s  = {1'b0, MAX_COUNT} - step_ext_s;

  // Clamp an incoming load value to the wrap limit.
  always_comb begin
    if (i_Load_Val > MAX_COUNT) begin
      o_Load_Clamped = MAX_COUNT;
    end else begin
      o_Load_Clamped = i_Load_Val;
    end
  end

  // Pick the advanced count: pending load first, then wrapping step.
  always_comb begin
    if (i_Load_Pending) begin
      o_Next_Count = i_Pending_Val;
    end else if (i_Dir) begin
      if (count_ext_s < step_ext_s) begin
        o_Next_Count = MAX_COUNT;
      end else begin
        o_Next_Count = i_Count - STEP;
      end
    end else begin
      if (count_ext_s > up_limit_s) begin
        o_Next_Count = {WIDTH{1'b0}};
      end else begin
        o_Next_Count = i_Count + STEP;
      end
    end
  end

endmodule

// File: rtl/uart_count_streamer.sv
// uart_count_streamer
//   WIDTH-bit up/down counter whose value is streamed to a UART TX as a
//   frame of WIDTH/8 bytes (MSB first), optionally preceded by SYNC_BYTE.
//   The counter only moves in the ADVANCE cycle after a frame, so the
//   transmitted bytes always match the snapshot taken at frame start.
// Ports:
//   i_Clk, i_Rst_n    clock, asynchronous active-low reset
//   i_Enable          stream continuously (sampled in IDLE)
//   i_Dir             0 = up, 1 = down (sampled in ADVANCE)
//   i_Load/i_Load_Val load strobe and value (clamped to MAX_COUNT)
//   i_Tx_Active       UART busy
//   i_Tx_Done         UART byte-complete pulse
//   o_Tx_DV/o_Tx_Byte byte-valid pulse and byte to the UART
//   o_Count           current counter value
//   o_Busy            frame in progress
//   o_Frame_Done      pulse coinciding with the count update
module uart_count_streamer
  import uart_stream_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] STEP      = WIDTH'(1),
  parameter bit               SYNC_EN   = 1'b1,
  parameter logic [7:0]       SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Enable,
  input  logic             i_Dir,
  input  logic             i_Load,
  input  logic [WIDTH-1:0] i_Load_Val,
  input  logic             i_Tx_Active,
  input  logic             i_Tx_Done,
  output logic             o_Tx_DV,
  output logic [7:0]       o_Tx_Byte,
  output logic [WIDTH-1:0] o_Count,
  output logic             o_Busy,
  output logic             o_Frame_Done
);

  localparam int         NB       = bytes_per_word(WIDTH) + (SYNC_EN ? 1 : 0);
  localparam logic [2:0] LAST_IDX = 3'(NB - 1);

  stream_state_e    state_r, state_s;
  logic [2:0]       idx_r, idx_s;
  logic [WIDTH-1:0] frame_r, frame_s;
  logic [WIDTH-1:0] count_r, count_s;
  logic             pend_r, pend_s;
  logic [WIDTH-1:0] pend_val_r, pend_val_s;
  logic             tx_dv_r, tx_dv_s;
  logic [7:0]       tx_byte_r, tx_byte_s;
  logic             done_r, done_s;
  logic             busy_r, busy_s;
  logic [WIDTH-1:0] next_count_s;
  logic [WIDTH-1:0] load_clamped_s;

  count_step_unit #(
    .WIDTH    (WIDTH),
    .MAX_COUNT(MAX_COUNT),
    .STEP     (STEP)
  ) u_step (
    .i_Count       (count_r),
    .i_Dir         (i_Dir),
    .i_Load_Pending(pend_r),
    .i_Pending_Val (pend_val_r),
    .i_Load_Val    (i_Load_Val),
    .o_Next_Count  (next_count_s),
    .o_Load_Clamped(load_clamped_s)
  );

  // Frame sequencer and counter next-state logic.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    frame_s    = frame_r;
    count_s    = count_r;
    pend_s     = pend_r;
    pend_val_s = pend_val_r;
    tx_dv_s    = 1'b0;
    tx_byte_s  = tx_byte_r;
    done_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (i_Enable && !i_Tx_Active) begin
          state_s = ST_ISSUE;
          idx_s   = 3'd0;
          frame_s = count_r;
          // A load racing the frame start is deferred so the snapshot
          // still carries the old count.
          if (i_Load) begin
            pend_s     = 1'b1;
            pend_val_s = load_clamped_s;
          end else begin
            pend_s = pend_r;
          end
        end else begin
          if (i_Load) begin
            count_s = load_clamped_s;
            pend_s  = 1'b0;
          end else begin
            count_s = count_r;
          end
        end
      end

      ST_ISSUE: begin
        if (!i_Tx_Active) begin
          tx_dv_s = 1'b1;
          state_s = ST_WAIT;
          if (SYNC_EN && (idx_r == 3'd0)) begin
            tx_byte_s = SYNC_BYTE;
          end else begin
            // Frame register shifts left so the next byte is always on top.
            tx_byte_s = frame_r[WIDTH-1 -: 8];
            frame_s   = frame_r << 4'd8;
          end
        end else begin
          state_s = ST_ISSUE;
        end
      end

      ST_WAIT: begin
        if (i_Tx_Done) begin
          if (idx_r == LAST_IDX) begin
            state_s = ST_ADVANCE;
          end else begin
            idx_s   = idx_r + 3'd1;
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end

      ST_ADVANCE: begin
        count_s = next_count_s;
        done_s  = 1'b1;
        pend_s  = 1'b0;
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Loads outside IDLE are held until the next ADVANCE; last one wins.
    // A strobe during ADVANCE re-arms for the following frame.
    if ((state_r != ST_IDLE) && i_Load) begin
      pend_s     = 1'b1;
      pend_val_s = load_clamped_s;
    end else begin
      pend_val_s = pend_val_s;
    end

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= 3'd0;
      frame_r    <= {WIDTH{1'b0}};
      count_r    <= {WIDTH{1'b0}};
      pend_r     <= 1'b0;
      pend_val_r <= {WIDTH{1'b0}};
      tx_dv_r    <= 1'b0;
      tx_byte_r  <= 8'h00;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      frame_r    <= frame_s;
      count_r    <= count_s;
      pend_r     <= pend_s;
      pend_val_r <= pend_val_s;
      tx_dv_r    <= tx_dv_s;
      tx_byte_r  <= tx_byte_s;
      done_r     <= done_s;
      busy_r     <= busy_s;
    end
  end

  assign o_Tx_DV      = tx_dv_r;
  assign o_Tx_Byte    = tx_byte_r;
  assign o_Count      = count_r;
  assign o_Busy       = busy_r;
  assign o_Frame_Done = done_r;

endmodule

// File: tb/tb_uart_count_streamer.sv
// tb_uart_count_streamer
//   Directed bench for uart_count_streamer (WIDTH=16, MAX_COUNT=1000,
//   STEP=3, SYNC_EN=1). A UART responder answers each DV with Active for
//   10 cycles and a Done pulse. A frame-level model predicts every output
//   on every cycle; literal expectations pin the model at key points.
module tb_uart_count_streamer;

  localparam int MAXC  = 1000;
  localparam int STEPV = 3;

  logic        i_Clk;
  logic        i_Rst_n;
  logic        i_Enable;
  logic        i_Dir;
  logic        i_Load;
  logic [15:0] i_Load_Val;
  logic        i_Tx_Done;
  logic        tx_active;
  logic        uart_active;
  logic        hold_active;
  logic        o_Tx_DV;
  logic [7:0]  o_Tx_Byte;
  logic [15:0] o_Count;
  logic        o_Busy;
  logic        o_Frame_Done;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [7:0] tx_log[$];

  assign tx_active = uart_active | hold_active;

  uart_count_streamer #(
    .WIDTH    (16),
    .MAX_COUNT(16'd1000),
    .STEP     (16'd3),
    .SYNC_EN  (1'b1),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst_n     (i_Rst_n),
    .i_Enable    (i_Enable),
    .i_Dir       (i_Dir),
    .i_Load      (i_Load),
    .i_Load_Val  (i_Load_Val),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (i_Tx_Done),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .o_Count     (o_Count),
    .o_Busy      (o_Busy),
    .o_Frame_Done(o_Frame_Done)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  logic [15:0] m_count;
  logic        m_busy, m_pend, m_ready, m_out, m_adv, m_dv, m_done;
  logic [15:0] m_pend_val;
  logic [7:0]  m_byte;
  logic [7:0]  m_bytes[$];

  function automatic logic [15:0] clampv(input logic [15:0] v);
    return (int'(v) > MAXC) ? 16'(MAXC) : v;
  endfunction

  function automatic logic [15:0] stepv(input logic [15:0] c, input logic dir);
    int v;
    v = int'(c);
    if (!dir) return (v + STEPV > MAXC) ? 16'd0 : 16'(v + STEPV);
    else      return (v < STEPV) ? 16'(MAXC) : 16'(v - STEPV);
  endfunction

  task automatic model_reset();
    m_count = 16'd0; m_busy = 1'b0; m_pend = 1'b0; m_pend_val = 16'd0;
    m_ready = 1'b0; m_out = 1'b0; m_adv = 1'b0; m_dv = 1'b0; m_done = 1'b0;
    m_byte = 8'h00; m_bytes.delete();
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    m_dv = 1'b0;
    m_done = 1'b0;
    if (m_adv) begin
      m_count = m_pend ? m_pend_val : stepv(m_count, i_Dir);
      m_pend = 1'b0; m_done = 1'b1; m_busy = 1'b0; m_adv = 1'b0;
      if (i_Load) begin m_pend = 1'b1; m_pend_val = clampv(i_Load_Val); end
    end else if (!m_busy) begin
      if (i_Enable && !tx_active) begin
        m_busy = 1'b1;
        m_bytes = '{8'hA5, m_count[15:8], m_count[7:0]};
        m_ready = 1'b1; m_out = 1'b0;
        if (i_Load) begin m_pend = 1'b1; m_pend_val = clampv(i_Load_Val); end
      end else if (i_Load) begin
        m_count = clampv(i_Load_Val);
        m_pend = 1'b0;
      end
    end else begin
      if (i_Load) begin m_pend = 1'b1; m_pend_val = clampv(i_Load_Val); end
      if (m_out) begin
        if (i_Tx_Done) begin
          m_out = 1'b0;
          if (m_bytes.size() == 0) m_adv = 1'b1;
          else m_ready = 1'b1;
        end
      end else if (m_ready && !tx_active) begin
        m_dv = 1'b1; m_byte = m_bytes.pop_front(); m_ready = 1'b0; m_out = 1'b1;
      end
    end
  endtask

  // Compare process: model advances at each rising edge, outputs checked at the falling edge.
  initial begin
    model_reset();
    forever begin
      @(posedge i_Clk);
      if (!i_Rst_n) model_reset();
      else model_step();
      @(negedge i_Clk);
      if (!i_Rst_n) begin
        model_reset();
        check("rst_outputs", {o_Tx_DV, o_Tx_Byte, o_Count, o_Busy, o_Frame_Done}, 32'd0);
      end else begin
        check("cyc_count", o_Count, m_count);
        check("cyc_busy", o_Busy, m_busy);
        check("cyc_dv", o_Tx_DV, m_dv);
        check("cyc_byte", o_Tx_Byte, m_byte);
        check("cyc_frame_done", o_Frame_Done, m_done);
      end
    end
  end

  always @(negedge i_Clk) if (o_Frame_Done === 1'b1) done_cnt++;

  // UART responder: Active for 10 cycles after each DV, then a Done pulse.
  initial begin
    uart_active = 1'b0;
    i_Tx_Done = 1'b0;
    forever begin
      @(negedge i_Clk);
      if (o_Tx_DV === 1'b1 && i_Rst_n === 1'b1) begin
        tx_log.push_back(o_Tx_Byte);
        @(posedge i_Clk); #2;
        uart_active = 1'b1;
        for (int k = 0; k < 10; k++) begin
          @(posedge i_Clk); #2;
          if (!i_Rst_n) break;
        end
        uart_active = 1'b0;
        if (i_Rst_n) begin
          i_Tx_Done = 1'b1;
          @(posedge i_Clk); #2;
          i_Tx_Done = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge i_Clk);
    #2;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge i_Clk);
      if (o_Frame_Done === 1'b1) begin seen = 1'b1; break; end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_timeout: got no frame-done, expected one within 300 cycles", tag);
    end
  endtask

  task automatic wait_dv(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge i_Clk);
      if (o_Tx_DV === 1'b1) begin seen = 1'b1; break; end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_dv_timeout: got no DV, expected one within 100 cycles", tag);
    end
  endtask

  task automatic finish_frame(input string tag, input int base, input logic [7:0] hi,
                              input logic [7:0] lo, input logic [15:0] exp_cnt);
    wait_done(tag);
    check({tag, "_nbytes"}, tx_log.size(), base + 3);
    if (tx_log.size() >= base + 3) begin
      check({tag, "_sync"}, tx_log[base], 8'hA5);
      check({tag, "_hi"}, tx_log[base+1], hi);
      check({tag, "_lo"}, tx_log[base+2], lo);
    end
    check({tag, "_count"}, o_Count, exp_cnt);
    tick(1);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                           input logic [15:0] exp_cnt);
    int base;
    base = tx_log.size();
    i_Enable = 1'b1;
    tick(1);
    i_Enable = 1'b0;
    finish_frame(tag, base, hi, lo, exp_cnt);
  endtask

  task automatic load_idle(input string tag, input logic [15:0] v, input logic [15:0] exp_cnt);
    i_Load = 1'b1;
    i_Load_Val = v;
    tick(1);
    i_Load = 1'b0;
    check(tag, o_Count, exp_cnt);
    tick(1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    i_Rst_n = 1'b0; i_Enable = 1'b0; i_Dir = 1'b0; i_Load = 1'b0;
    i_Load_Val = 16'd0; hold_active = 1'b0;
    tick(3);
    check("reset_count", o_Count, 16'd0);
    check("reset_busy", o_Busy, 1'b0);
    @(posedge i_Clk); #3;
    i_Rst_n = 1'b1;
    tick(2);

    // First frame from reset.
    run_frame("f_first", 8'h00, 8'h00, 16'd3);
    check("f_first_done_once", done_cnt, 1);

    // Up-count wrap boundary: 997 -> 1000 (exactly at limit) -> 0.
    load_idle("ld_997", 16'd997, 16'd997);
    run_frame("up_997", 8'h03, 8'hE5, 16'd1000);
    run_frame("up_1000", 8'h03, 8'hE8, 16'd0);

    // Down-count wrap boundary.
    i_Dir = 1'b1;
    load_idle("ld_1", 16'd1, 16'd1);
    run_frame("dn_1", 8'h00, 8'h01, 16'd1000);
    run_frame("dn_1000", 8'h03, 8'hE8, 16'd997);
    load_idle("ld_3", 16'd3, 16'd3);
    run_frame("dn_3", 8'h00, 8'h03, 16'd0);
    i_Dir = 1'b0;

    // Load during WAIT is deferred; frame still carries 5.
    load_idle("ld_5", 16'd5, 16'd5);
    base = tx_log.size();
    i_Enable = 1'b1;
    tick(1);
    i_Enable = 1'b0;
    wait_dv("pend");
    tick(3);
    i_Load = 1'b1; i_Load_Val = 16'h0234;
    tick(1);
    i_Load = 1'b0;
    check("pend_count_frozen", o_Count, 16'd5);
    finish_frame("pend", base, 8'h00, 8'h05, 16'h0234);
    run_frame("pend_next", 8'h02, 8'h34, 16'h0237);

    // Load clamp.
    load_idle("ld_clamp", 16'hFFFF, 16'd1000);

    // Load coinciding with frame start: old count sent, load applied at end.
    base = tx_log.size();
    i_Enable = 1'b1; i_Load = 1'b1; i_Load_Val = 16'd50;
    tick(1);
    i_Enable = 1'b0; i_Load = 1'b0;
    check("coinc_count_held", o_Count, 16'd1000);
    finish_frame("coinc", base, 8'h03, 8'hE8, 16'd50);

    // Tx_Active held high in ISSUE: no DV until it drops.
    base = tx_log.size();
    i_Enable = 1'b1;
    tick(1);
    i_Enable = 1'b0;
    hold_active = 1'b1;
    tick(20);
    check("hold_no_dv", tx_log.size(), base);
    check("hold_busy", o_Busy, 1'b1);
    hold_active = 1'b0;
    finish_frame("hold", base, 8'h00, 8'h32, 16'd53);

    // Reset in WAIT: outputs clear at once, no DV right after release.
    i_Enable = 1'b1;
    tick(1);
    i_Enable = 1'b0;
    wait_dv("rst_mid");
    tick(2);
    #1;
    i_Rst_n = 1'b0;
    #1;
    check("rst_async_count", o_Count, 16'd0);
    check("rst_async_busy", o_Busy, 1'b0);
    check("rst_async_byte", o_Tx_Byte, 8'h00);
    tick(3);
    @(posedge i_Clk); #3;
    i_Rst_n = 1'b1;
    @(negedge i_Clk);
    check("rst_release_dv", o_Tx_DV, 1'b0);
    tick(15);
    run_frame("post_rst", 8'h00, 8'h00, 16'd3);

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_count_streamer.md
Name: uart_count_streamer

Overview:
Parametrised successor to the single-byte UART counter. Holds a WIDTH-bit counter with up/down mode, step, programmable wrap limit and synchronous load. Streams each count value to the UART transmitter as a frame of WIDTH/8 bytes, MSB first, with an optional sync byte in front. Sits between control logic and the UART TX, using the existing Tx_DV / Tx_Active / Tx_Done handshake.

Parameters:
WIDTH, 16, counter width in bits; must be a multiple of 8, range 8..32
MAX_COUNT, 2**WIDTH-1, wrap limit (inclusive upper bound)
STEP, 1, increment/decrement per frame; 1..MAX_COUNT
SYNC_EN, 1, 1 = prefix each frame with SYNC_BYTE
SYNC_BYTE, 8'hA5, sync/header byte value

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Enable  in  1  1 = stream frames continuously; sampled only in IDLE
i_Dir  in  1  0 = count up, 1 = count down; sampled in ADVANCE
i_Load  in  1  one-cycle load strobe
i_Load_Val  in  WIDTH  load value
i_Tx_Active  in  1  UART TX busy
i_Tx_Done  in  1  UART TX one-cycle byte-complete pulse
o_Tx_DV  out  1  one-cycle byte-valid pulse to UART
o_Tx_Byte  out  8  byte to transmit; stable from the DV cycle until the next DV
o_Count  out  WIDTH  current counter value
o_Busy  out  1  1 = a frame is in progress (state other than IDLE)
o_Frame_Done  out  1  one-cycle pulse after the last byte of a frame, when the count updates

Behaviour:
- Reset (async, i_Rst_n=0):
  - o_Count=0, o_Tx_DV=0, o_Tx_Byte=0, o_Busy=0, o_Frame_Done=0.
  - Byte index 0, pending-load flag 0, state IDLE.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, ADVANCE.
- IDLE: if i_Enable=1 and i_Tx_Active=0:
  - snapshot o_Count into frame register;
  - byte index 0;
  - go to ISSUE.
- ISSUE:
  - if i_Tx_Active=0: assert o_Tx_DV for exactly one cycle, drive o_Tx_Byte, go to WAIT.
  - otherwise hold in ISSUE with no DV.
  - Byte order:
    - SYNC_BYTE first (if SYNC_EN=1);
    - then frame[WIDTH-1:WIDTH-8] down to frame[7:0].
  - Frame length: NB = WIDTH/8 + SYNC_EN bytes.
- WAIT: on i_Tx_Done=1:
  - if the index has not reached NB-1: increment the index, go to ISSUE;
  - otherwise go to ADVANCE.
  - i_Tx_Done seen in any other state is ignored.
- ADVANCE (one cycle), then IDLE:
  - update o_Count and pulse o_Frame_Done.
  - Update priority: pending load > step.
- Load:
  - Load value = min(i_Load_Val, MAX_COUNT).
  - i_Load in IDLE updates o_Count on the next cycle. If it coincides with an IDLE→ISSUE start, the snapshot takes the old count and the load is applied in ADVANCE.
  - i_Load in ISSUE/WAIT/ADVANCE sets the pending flag and latches the value. The last strobe wins; it is applied at the next ADVANCE and the flag is then cleared.
- Step arithmetic (WIDTH+1-bit compare, no overflow):
  - up: if o_Count > MAX_COUNT-STEP, then o_Count=0; else o_Count+STEP.
  - down: if o_Count < STEP, then o_Count=MAX_COUNT; else o_Count-STEP.
- The transmitted frame always equals the snapshot; o_Count never changes mid-frame.
- i_Enable dropped mid-frame: the frame completes, including ADVANCE, then stays in IDLE.
- Latency:
  - IDLE→first DV: 2 cycles after the enable condition is sampled.
  - Done→next DV: ≥2 cycles (WAIT→ISSUE→DV).
  - Last Done→o_Frame_Done: 1 cycle.
- o_Busy=1 in ISSUE, WAIT and ADVANCE.
- Reset mid-frame aborts immediately; o_Tx_DV must not be asserted in the cycle after release.

Decomposition:
- Shared package uart_stream_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, ADVANCE);
  - default SYNC_BYTE constant;
  - function for bytes-per-word (WIDTH/8).
- One natural sub-module: count_step_unit (combinational/registered next-count logic: wrap, step, direction, load clamp), reusable by future multi-channel streamers.

Test Plan:
- Reset then enable, WIDTH=16, SYNC_EN=1, UART model with Done 10 cycles after DV → bytes A5,00,00; o_Frame_Done once; o_Count=1.
- Up wrap, MAX_COUNT=9, STEP=4, load 8 → frame carries 8; next count 0 (8 > 9-4); next frames 0,4,8,0.
- Down mode, STEP=3, MAX_COUNT=100, load 1 → frame carries 1; count becomes 100; next 97.
- Load 0x1234 during WAIT of frame carrying 5 → remaining bytes still 00,05; after ADVANCE o_Count=0x1234 (not 6); next frame A5,12,34.
- Load 0xFFFF with MAX_COUNT=1000 → o_Count=1000 (clamped).
- Hold i_Tx_Active=1 for 20 cycles in ISSUE → no o_Tx_DV until it drops, then exactly one DV. Assert i_Rst_n=0 in WAIT → all outputs 0 asynchronously; no DV in the cycle after release.
